// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle data memory for the pipeline MEM stage.
// Accepts one load/store at a time over a valid/ready handshake, waits LATENCY
// cycles, then holds the response until it is taken; Stall freezes the pipe meanwhile.
// Optional macro DMEM_ALIGN_CHECK_EN: fault misaligned word/halfword accesses.
// Ports:
//   Clk, Reset                 clock (rising edge), async active-high reset
//   ReqValid/ReqReady          request handshake; ReqAddr byte address, ReqWData store data
//   MemWrite/MemRead           size codes: 00 none, 01 word, 10 halfword, 11 byte
//   RspValid/RspReady          response handshake; RspRData load result, RspErr fault flag
//   Stall                      high while busy or while a request is being accepted
module data_mem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWData,
  input  logic [1:0]  MemWrite,
  input  logic [1:0]  MemRead,
  output logic        RspValid,
  input  logic        RspReady,
  output logic [31:0] RspRData,
  output logic        RspErr,
  output logic        Stall
);

  localparam logic [1:0] SZ_WORD = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_BYTE = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  mw_q;
  logic [1:0]  mr_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem_q [0:(1<<ADDR_W)-1];

  logic [ADDR_W-1:0] idx_c;
  logic [31:0]       word_c;
  logic [7:0]        byte_c;
  logic [15:0]       half_c;
  logic              misalign_c;
  logic              err_d;
  logic [31:0]       rdata_d;
  logic [3:0]        be_c;
  logic [31:0]       wdat_c;
  logic              commit_c;
  logic              we_c;

  // Everything below works on the captured request, never on live inputs.
  assign idx_c  = addr_q[ADDR_W+1:2];
  assign word_c = mem_q[idx_c];
  assign byte_c = word_c[{addr_q[1:0], 3'b000} +: 8];
  assign half_c = addr_q[1] ? word_c[31:16] : word_c[15:0];

`ifdef DMEM_ALIGN_CHECK_EN
  logic [1:0] size_c;
  // A conflicting request already faults, so either code may pick the size.
  assign size_c     = (mw_q != 2'b00) ? mw_q : mr_q;
  assign misalign_c = ((size_c == SZ_WORD) && (addr_q[1:0] != 2'b00)) ||
                      ((size_c == SZ_HALF) && addr_q[0]);
`else
  assign misalign_c = 1'b0;
`endif

  assign err_d = (|addr_q[31:ADDR_W+2]) ||
                 ((mw_q != 2'b00) && (mr_q != 2'b00)) ||
                 misalign_c;

  always_comb begin
    rdata_d = 32'h0;
    if (!err_d && (mw_q == 2'b00)) begin
      case (mr_q)
        SZ_WORD: rdata_d = word_c;
        SZ_HALF: rdata_d = {{16{half_c[15]}}, half_c};
        SZ_BYTE: rdata_d = {{24{byte_c[7]}}, byte_c};
        default: rdata_d = 32'h0;
      endcase
    end
  end

  // Narrow stores replicate the low lane so the byte enable alone picks the target.
  always_comb begin
    be_c   = 4'b0000;
    wdat_c = wdata_q;
    case (mw_q)
      SZ_WORD: be_c = 4'b1111;
      SZ_HALF: begin
        be_c   = addr_q[1] ? 4'b1100 : 4'b0011;
        wdat_c = {2{wdata_q[15:0]}};
      end
      SZ_BYTE: begin
        be_c   = 4'b0001 << addr_q[1:0];
        wdat_c = {4{wdata_q[7:0]}};
      end
      default: be_c = 4'b0000;
    endcase
  end

  // The access happens on the edge that leaves WAIT; reset drops state to IDLE
  // first, so a store interrupted by reset never commits.
  assign commit_c = (state_q == S_WAIT) && (cnt_q == 4'd0);
  assign we_c     = commit_c && (mw_q != 2'b00) && !err_d;

  always_ff @(posedge Clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we_c && be_c[b]) begin
        mem_q[idx_c][b*8 +: 8] <= wdat_c[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      mw_q    <= 2'b00;
      mr_q    <= 2'b00;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ReqValid) begin
            state_q <= S_WAIT;
            cnt_q   <= 4'(LATENCY - 1);
            addr_q  <= ReqAddr;
            wdata_q <= ReqWData;
            mw_q    <= MemWrite;
            mr_q    <= MemRead;
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= S_RESP;
            rdata_q <= rdata_d;
            err_q   <= err_d;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          if (RspReady) begin
            state_q <= S_IDLE;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ReqReady = (state_q == S_IDLE);
  assign RspValid = (state_q == S_RESP);
  assign RspRData = rdata_q;
  assign RspErr   = err_q;
  // The acceptance-cycle term lets the pipeline freeze before the FSM leaves IDLE.
  assign Stall    = (state_q != S_IDLE) || ReqValid;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  localparam int LAT = 2;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        ReqValid;
  logic        ReqReady;
  logic [31:0] ReqAddr;
  logic [31:0] ReqWData;
  logic [1:0]  MemWrite;
  logic [1:0]  MemRead;
  logic        RspValid;
  logic        RspReady;
  logic [31:0] RspRData;
  logic        RspErr;
  logic        Stall;

  int checks = 0;
  int errors = 0;

  data_mem_responder #(.ADDR_W(10), .LATENCY(LAT)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .ReqValid (ReqValid),
    .ReqReady (ReqReady),
    .ReqAddr  (ReqAddr),
    .ReqWData (ReqWData),
    .MemWrite (MemWrite),
    .MemRead  (MemRead),
    .RspValid (RspValid),
    .RspReady (RspReady),
    .RspRData (RspRData),
    .RspErr   (RspErr),
    .Stall    (Stall)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction: accept, count latency, optionally hold the response
  // under backpressure, then hand it off and confirm the responder is free.
  task automatic do_req(input string tag, input logic [1:0] mw, input logic [1:0] mr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_data, input logic exp_err, input int hold);
    int cycles;
    @(negedge Clk);
    ReqValid = 1'b1;
    MemWrite = mw;
    MemRead  = mr;
    ReqAddr  = addr;
    ReqWData = wdata;
    #1;
    check({tag, ".acc_ready"}, 32'(ReqReady), 32'd1);
    check({tag, ".acc_stall"}, 32'(Stall), 32'd1);
    @(posedge Clk);
    #1;
    // Scramble inputs: the responder must use only what it captured.
    ReqValid = 1'b0;
    MemWrite = 2'b00;
    MemRead  = 2'b00;
    ReqAddr  = 32'hFFFF_FFFF;
    ReqWData = 32'h5A5A_5A5A;
    check({tag, ".wait_stall"}, 32'(Stall), 32'd1);
    check({tag, ".wait_ready"}, 32'(ReqReady), 32'd0);
    cycles = 0;
    for (int i = 0; i < 20; i++) begin
      if (RspValid === 1'b1) break;
      @(posedge Clk);
      #1;
      cycles++;
    end
    check({tag, ".latency"}, 32'(cycles), 32'(LAT));
    check({tag, ".rdata"}, RspRData, exp_data);
    check({tag, ".err"}, 32'(RspErr), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      @(posedge Clk);
      #1;
      check({tag, ".hold_valid"}, 32'(RspValid), 32'd1);
      check({tag, ".hold_rdata"}, RspRData, exp_data);
      check({tag, ".hold_err"}, 32'(RspErr), 32'(exp_err));
      check({tag, ".hold_stall"}, 32'(Stall), 32'd1);
      check({tag, ".hold_ready"}, 32'(ReqReady), 32'd0);
    end
    RspReady = 1'b1;
    @(posedge Clk);
    #1;
    RspReady = 1'b0;
    check({tag, ".post_ready"}, 32'(ReqReady), 32'd1);
    check({tag, ".post_valid"}, 32'(RspValid), 32'd0);
    check({tag, ".post_stall"}, 32'(Stall), 32'd0);
  endtask

  initial begin
    Reset    = 1'b1;
    ReqValid = 1'b0;
    ReqAddr  = 32'h0;
    ReqWData = 32'h0;
    MemWrite = 2'b00;
    MemRead  = 2'b00;
    RspReady = 1'b0;
    #1;
    check("rst.ready", 32'(ReqReady), 32'd1);
    check("rst.valid", 32'(RspValid), 32'd0);
    check("rst.rdata", RspRData, 32'h0);
    check("rst.err",   32'(RspErr), 32'd0);
    check("rst.stall", 32'(Stall), 32'd0);
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;

    // Word store then load
    do_req("st_w10", 2'b01, 2'b00, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 0);
    do_req("ld_w10", 2'b00, 2'b01, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0);

    // Narrow access
    do_req("st_w20", 2'b01, 2'b00, 32'h20, 32'h11223380, 32'h0, 1'b0, 0);
    do_req("ld_b20", 2'b00, 2'b11, 32'h20, 32'h0, 32'hFFFFFF80, 1'b0, 0);
    do_req("st_b23", 2'b11, 2'b00, 32'h23, 32'hAAAAAA7F, 32'h0, 1'b0, 0);
    do_req("ld_w20", 2'b00, 2'b01, 32'h20, 32'h0, 32'h7F223380, 1'b0, 0);
    do_req("ld_b21", 2'b00, 2'b11, 32'h21, 32'h0, 32'h00000033, 1'b0, 0);
    do_req("ld_h20", 2'b00, 2'b10, 32'h20, 32'h0, 32'h00003380, 1'b0, 0);

    // Halfword
    do_req("st_w40", 2'b01, 2'b00, 32'h40, 32'h55556666, 32'h0, 1'b0, 0);
    do_req("st_h42", 2'b10, 2'b00, 32'h42, 32'hBBBB8001, 32'h0, 1'b0, 0);
    do_req("ld_h42", 2'b00, 2'b10, 32'h42, 32'h0, 32'hFFFF8001, 1'b0, 0);
    do_req("ld_w40", 2'b00, 2'b01, 32'h40, 32'h0, 32'h80016666, 1'b0, 0);

    // Backpressure
    do_req("bp_w10", 2'b00, 2'b01, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 5);

    // Errors: out of range must not alias onto word 0
    do_req("st_w00", 2'b01, 2'b00, 32'h0, 32'h01020304, 32'h0, 1'b0, 0);
    do_req("st_oor", 2'b01, 2'b00, 32'h1000, 32'h12345678, 32'h0, 1'b1, 0);
    do_req("ld_oor", 2'b00, 2'b01, 32'h1000, 32'h0, 32'h0, 1'b1, 0);
    do_req("ld_w00", 2'b00, 2'b01, 32'h0, 32'h0, 32'h01020304, 1'b0, 0);
    do_req("both",   2'b01, 2'b01, 32'h10, 32'h0, 32'h0, 1'b1, 0);
    do_req("ld_w10b", 2'b00, 2'b01, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0);
`ifdef DMEM_ALIGN_CHECK_EN
    do_req("ld_w12", 2'b00, 2'b01, 32'h12, 32'h0, 32'h0, 1'b1, 0);
`else
    do_req("ld_w12", 2'b00, 2'b01, 32'h12, 32'h0, 32'hDEADBEEF, 1'b0, 0);
`endif

    // Nop
    do_req("nop", 2'b00, 2'b00, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b0, 0);

    // Reset mid-WAIT on a store
    do_req("st_w30", 2'b01, 2'b00, 32'h30, 32'hCAFEF00D, 32'h0, 1'b0, 0);
    @(negedge Clk);
    ReqValid = 1'b1;
    MemWrite = 2'b01;
    MemRead  = 2'b00;
    ReqAddr  = 32'h30;
    ReqWData = 32'h12345678;
    @(posedge Clk);
    #1;
    ReqValid = 1'b0;
    MemWrite = 2'b00;
    check("mid.busy", 32'(ReqReady), 32'd0);
    Reset = 1'b1;
    #1;
    check("mid.ready", 32'(ReqReady), 32'd1);
    check("mid.valid", 32'(RspValid), 32'd0);
    check("mid.rdata", RspRData, 32'h0);
    check("mid.err",   32'(RspErr), 32'd0);
    check("mid.stall", 32'(Stall), 32'd0);
    @(posedge Clk);
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge Clk);
      #1;
      check("mid.no_rsp", 32'(RspValid), 32'd0);
    end
    do_req("ld_w30", 2'b00, 2'b01, 32'h30, 32'h0, 32'hCAFEF00D, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
